// File: rtl/display_pkg.sv
// display_pkg
//   Shared definitions for the 4-digit 7-segment scan/arbiter slice:
//   owner state encoding, blank/off constants, digit count and the
//   BCD-to-7-segment decoder (active-low, gfedcba).
package display_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } owner_t;

   localparam logic [6:0]  SEG_BLANK  = 7'h7F;
   localparam logic [3:0]  AN_OFF     = 4'hF;
   localparam int unsigned NUM_DIGITS = 4;

   // Active-low segment pattern for one BCD digit; non-BCD codes blank.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
      logic [6:0] s;
      case (bcd)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/display_scan_timer.sv
// display_scan_timer
//   Free-running digit scan timebase: slot counter 0..SCAN_DIV-1 and digit
//   index 0..3. Outputs are combinational views used by the owner logic:
//     digit_nxt - digit index that will be current after the next edge
//     blank_nxt - slot after the next edge lies in the anode-off interval
//     boundary  - current cycle is the last cycle of the digit-3 slot
//   Ports: clk, rst (async, active-low), digit_nxt[1:0], blank_nxt, boundary.
module display_scan_timer
   import display_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 50_000,
   parameter int unsigned BLANK_CYCLES = 1_000
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] digit_nxt,
   output logic       blank_nxt,
   output logic       boundary
);

   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [SW-1:0] slot;
   logic [SW-1:0] slot_nxt;
   logic [1:0]    digit;
   logic          slot_end;

   always_comb begin
      slot_end  = (slot == SW'(SCAN_DIV - 1));
      slot_nxt  = slot_end ? '0 : slot + 1'b1;
      digit_nxt = slot_end ? digit + 2'd1 : digit;
      boundary  = slot_end && (digit == 2'(NUM_DIGITS - 1));
      blank_nxt = (slot_nxt < SW'(BLANK_CYCLES));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot  <= '0;
         digit <= '0;
      end else begin
         slot  <= slot_nxt;
         digit <= digit_nxt;
      end
   end

endmodule

// File: rtl/display_scan_arbiter.sv
// display_scan_arbiter
//   Grants the 4-digit display to one of two BCD producers, latches the
//   owner's digits at frame boundaries and drives a blanked digit scan.
//   Ports:
//     clk, rst (async, active-low)
//     req[1:0]       level requests
//     digits0/1[15:0] BCD digits, [15:12] leftmost
//     gnt[1:0]       one-hot-or-zero owner
//     frame_start    pulse on first cycle of each frame
//     an[3:0]        anode enables, active-low
//     seg[6:0]       segments, active-low (gfedcba)
module display_scan_arbiter
   import display_pkg::*;
#(
   parameter int unsigned SCAN_DIV        = 50_000,
   parameter int unsigned BLANK_CYCLES    = 1_000,
   parameter int unsigned MIN_HOLD_FRAMES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [15:0] digits0,
   input  logic [15:0] digits1,
   output logic [1:0]  gnt,
   output logic        frame_start,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   owner_t      state;
   owner_t      state_nxt;
   logic [7:0]  hold_cnt;
   logic [15:0] shadow;
   logic [15:0] shadow_nxt;
   logic [3:0]  nib_nxt;
   logic        hold_done;
   logic [1:0]  digit_nxt;
   logic        blank_nxt;
   logic        boundary;

   display_scan_timer #(
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .digit_nxt (digit_nxt),
      .blank_nxt (blank_nxt),
      .boundary  (boundary)
   );

   // an/seg are registered from next-cycle values so they line up with
   // gnt and the scan counters instead of lagging them by one cycle.
   always_comb begin
      hold_done = (hold_cnt >= 8'(MIN_HOLD_FRAMES));
      state_nxt = state;
      if (boundary) begin
         case (state)
            IDLE: begin
               if (req[0])      state_nxt = OWN0;
               else if (req[1]) state_nxt = OWN1;
            end
            OWN0: begin
               if (!req[0])                  state_nxt = req[1] ? OWN1 : IDLE;
               else if (req[1] && hold_done) state_nxt = OWN1;
            end
            OWN1: begin
               if (!req[1])                  state_nxt = req[0] ? OWN0 : IDLE;
               else if (req[0] && hold_done) state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
         endcase
      end

      shadow_nxt = shadow;
      if (boundary) begin
         if (state_nxt == OWN0)      shadow_nxt = digits0;
         else if (state_nxt == OWN1) shadow_nxt = digits1;
      end

      nib_nxt = shadow_nxt[{digit_nxt, 2'b00} +: 4];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         gnt         <= '0;
         hold_cnt    <= '0;
         shadow      <= '0;
         frame_start <= 1'b0;
         an          <= AN_OFF;
         seg         <= SEG_BLANK;
      end else begin
         state       <= state_nxt;
         gnt         <= state_nxt;
         shadow      <= shadow_nxt;
         frame_start <= boundary;

         if (boundary) begin
            if (state_nxt != state)
               hold_cnt <= '0;
            else if (state != IDLE && hold_cnt != '1)
               hold_cnt <= hold_cnt + 8'd1;
         end

         if (state_nxt == IDLE || blank_nxt) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
         end else begin
            an  <= ~(4'b0001 << digit_nxt);
            seg <= bcd_to_seg(nib_nxt);
         end
      end
   end

endmodule

// File: tb/tb_display_scan_arbiter.sv
// tb_display_scan_arbiter
//   Table-driven phases, hand-written corner sequences and a random phase,
//   all checked cycle by cycle against a frame-level behavioural model.
module tb_display_scan_arbiter;

   localparam int unsigned SD = 8;
   localparam int unsigned BC = 2;
   localparam int unsigned MH = 2;
   localparam int          FR = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [15:0] digits0;
   logic [15:0] digits1;
   logic [1:0]  gnt;
   logic        frame_start;
   logic [3:0]  an;
   logic [6:0]  seg;

   display_scan_arbiter #(
      .SCAN_DIV        (SD),
      .BLANK_CYCLES    (BC),
      .MIN_HOLD_FRAMES (MH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .digits0     (digits0),
      .digits1     (digits1),
      .gnt         (gnt),
      .frame_start (frame_start),
      .an          (an),
      .seg         (seg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: n = clock edges since reset release; owner -1 idle, 0 or 1.
   int          n;
   int          owner;
   int          hold;
   logic [15:0] shadow_m;

   typedef struct {
      logic [1:0]  req;
      logic [15:0] d0;
      logic [15:0] d1;
      int          frames;
      logic [1:0]  gnt;
   } vec_t;

   vec_t vecs [6];

   function automatic logic [6:0] seg_code(input logic [3:0] nib);
      case (nib)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at n=%0d: got %h, expected %h", name, n, act, exp);
      end
   endtask

   task automatic model_reset();
      n        = 0;
      owner    = -1;
      hold     = 0;
      shadow_m = 16'h0000;
   endtask

   // Decisions happen at edges that end a 32-cycle frame.
   task automatic model_edge();
      int nxt;
      int other;
      n++;
      if (n % FR == 0) begin
         nxt = owner;
         if (owner < 0) begin
            if (req[0])      nxt = 0;
            else if (req[1]) nxt = 1;
         end else begin
            other = 1 - owner;
            if (!req[owner])                       nxt = req[other] ? other : -1;
            else if (req[other] && hold >= int'(MH)) nxt = other;
         end
         if (nxt != owner)               hold = 0;
         else if (owner >= 0 && hold < 255) hold++;
         owner = nxt;
         if (owner == 0) shadow_m = digits0;
         if (owner == 1) shadow_m = digits1;
      end
   endtask

   task automatic check_all();
      int          slot;
      int          dig;
      logic [3:0]  exp_an;
      logic [6:0]  exp_seg;
      logic [1:0]  exp_gnt;
      logic [15:0] sh;
      slot    = n % int'(SD);
      dig     = (n / int'(SD)) % 4;
      exp_gnt = (owner < 0) ? 2'b00 : (owner == 0 ? 2'b01 : 2'b10);
      sh      = shadow_m;
      if (owner >= 0 && slot >= int'(BC)) begin
         exp_an  = 4'hF & ~(4'h1 << dig);
         exp_seg = seg_code(sh[dig*4 +: 4]);
      end else begin
         exp_an  = 4'hF;
         exp_seg = 7'h7F;
      end
      chk("gnt", 16'(gnt), 16'(exp_gnt));
      chk("frame_start", 16'(frame_start), 16'((n > 0 && n % FR == 0) ? 1 : 0));
      chk("an", 16'(an), 16'(exp_an));
      chk("seg", 16'(seg), 16'(exp_seg));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic run_to(input int target);
      while (n < target) step();
   endtask

   task automatic apply_vec(input int i);
      req     = vecs[i].req;
      digits0 = vecs[i].d0;
      digits1 = vecs[i].d1;
      run_to(n + vecs[i].frames * FR);
      chk($sformatf("vec%0d_gnt", i), 16'(gnt), 16'(vecs[i].gnt));
   endtask

   initial begin
      vecs[0] = '{req: 2'b00, d0: 16'h0000, d1: 16'h0000, frames: 3, gnt: 2'b00};
      vecs[1] = '{req: 2'b01, d0: 16'h1234, d1: 16'h0000, frames: 1, gnt: 2'b01};
      vecs[2] = '{req: 2'b11, d0: 16'h1234, d1: 16'h5678, frames: 1, gnt: 2'b01};
      vecs[3] = '{req: 2'b11, d0: 16'h1234, d1: 16'h5678, frames: 1, gnt: 2'b10};
      vecs[4] = '{req: 2'b00, d0: 16'h1234, d1: 16'h5678, frames: 1, gnt: 2'b00};
      vecs[5] = '{req: 2'b11, d0: 16'h1234, d1: 16'h5678, frames: 1, gnt: 2'b01};

      rst     = 1'b1;
      req     = 2'b00;
      digits0 = 16'h0000;
      digits1 = 16'h0000;
      model_reset();
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", 16'(an), 16'h000F);
      chk("rst_seg", 16'(seg), 16'h007F);
      chk("rst_gnt", 16'(gnt), 16'h0000);
      chk("rst_fs", 16'(frame_start), 16'h0000);
      rst = 1'b1;
      model_reset();

      // Idle frames, then owner 0 with 1234.
      for (int i = 0; i < 2; i++) apply_vec(i);
      chk("d0_blank_an", 16'(an), 16'h000F);
      run_to(130);
      chk("d0_an", 16'(an), 16'h000E);
      chk("d0_seg4", 16'(seg), 16'h0019);
      run_to(154);
      chk("d3_an", 16'(an), 16'h0007);
      chk("d3_seg1", 16'(seg), 16'h0079);
      run_to(160);

      // Hold contention, release to idle, fixed priority from idle.
      for (int i = 2; i < 6; i++) apply_vec(i);

      // Owner 0 drops mid-frame: switch only at the boundary.
      run_to(300);
      req = 2'b10;
      run_to(319);
      chk("drop_early_gnt", 16'(gnt), 16'h0001);
      run_to(320);
      chk("drop_gnt", 16'(gnt), 16'h0002);

      // Blank nibbles and mid-frame digit changes.
      req     = 2'b01;
      digits0 = 16'hFA90;
      run_to(352);
      chk("fa90_gnt", 16'(gnt), 16'h0001);
      run_to(354);
      chk("fa90_d0", 16'(seg), 16'h0040);
      run_to(356);
      digits0 = 16'h1111;
      run_to(362);
      chk("fa90_d1", 16'(seg), 16'h0010);
      run_to(372);
      chk("fa90_d2_an", 16'(an), 16'h000B);
      chk("fa90_d2", 16'(seg), 16'h007F);
      run_to(378);
      chk("fa90_d3", 16'(seg), 16'h007F);
      run_to(386);
      chk("new_d0", 16'(seg), 16'h0079);
      run_to(388);

      // Asynchronous reset while an anode is active.
      rst = 1'b0;
      #1;
      chk("arst_an", 16'(an), 16'h000F);
      chk("arst_seg", 16'(seg), 16'h007F);
      chk("arst_gnt", 16'(gnt), 16'h0000);
      chk("arst_fs", 16'(frame_start), 16'h0000);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      run_to(FR + 3);
      chk("post_rst_an", 16'(an), 16'h000E);

      // Random requests and digits, including short drop/re-raise pulses.
      for (int c = 0; c < 40 * FR; c++) begin
         if ($urandom_range(15) == 0) req = 2'($urandom);
         if ($urandom_range(7) == 0)  digits0 = 16'($urandom);
         if ($urandom_range(7) == 0)  digits1 = 16'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
